// File: rtl/id_stage_ctrl_pkg.sv
// Shared decode-stage definitions: RV32 major opcodes (inst[6:2]), the NOP encoding
// and the ID controller state enum.
package id_stage_ctrl_pkg;

  localparam int unsigned OPC_W = 5;
  localparam int unsigned REG_W = 5;
  localparam int unsigned INST_W = 32;

  localparam logic [OPC_W-1:0] OP_I_LOAD = 5'b00000;
  localparam logic [OPC_W-1:0] OP_FLW    = 5'b00001;
  localparam logic [OPC_W-1:0] OP_AUIPC  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_S_TYPE = 5'b01000;
  localparam logic [OPC_W-1:0] OP_FSW    = 5'b01001;
  localparam logic [OPC_W-1:0] OP_R_TYPE = 5'b01100;
  localparam logic [OPC_W-1:0] OP_LUI    = 5'b01101;
  localparam logic [OPC_W-1:0] OP_B_TYPE = 5'b11000;
  localparam logic [OPC_W-1:0] OP_JALR   = 5'b11001;
  localparam logic [OPC_W-1:0] OP_JAL    = 5'b11011;
  localparam logic [OPC_W-1:0] OP_CSR    = 5'b11100;

  // addi x0,x0,0
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_HAZ   = 2'd2
  } id_state_e;

endpackage

// File: rtl/id_stage_ctrl_if.sv
// Fetch -> ID -> EX hand-off bundle. The slave modport is the ID controller; the
// master modport is its pipeline neighbourhood (fetch and EX).
interface id_stage_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_inst;
  logic [XLEN-1:0] if_pc;
  logic            flush;
  logic            ex_ready;
  logic            ex_valid;
  logic            ex_is_load;
  logic [4:0]      ex_rd;
  logic            id_valid;
  logic [31:0]     id_inst;
  logic [XLEN-1:0] id_pc;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic            hazard_stall;

  modport master (
    output if_valid, if_inst, if_pc, flush, ex_ready, ex_valid, ex_is_load, ex_rd,
    input  if_ready, id_valid, id_inst, id_pc, id_rs1, id_rs2, id_rd, hazard_stall
  );

  modport slave (
    input  if_valid, if_inst, if_pc, flush, ex_ready, ex_valid, ex_is_load, ex_rd,
    output if_ready, id_valid, id_inst, id_pc, id_rs1, id_rs2, id_rd, hazard_stall
  );
endinterface

// File: rtl/id_stage_ctrl_src_use.sv
// Opcode -> source-register usage decode, used to qualify load-use hazard detection.
module id_src_use
  import id_stage_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output logic             use_rs1,
  output logic             use_rs2
);

  always_comb begin
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    if ((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL)) begin
      use_rs1 = 1'b0;
    end
    if ((opcode == OP_R_TYPE) || (opcode == OP_S_TYPE) || (opcode == OP_B_TYPE)) begin
      use_rs2 = 1'b1;
    end
  end

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage controller: IF/ID pipeline register, load-use bubble insertion,
// branch flush and stall-cycle counting.
module id_stage_ctrl #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned CNT_W    = 32,
  parameter logic [31:0] NOP_INST = id_stage_ctrl_pkg::NOP_INST
) (
  input  logic             clk,
  input  logic             rst,
  id_stage_ctrl_if.slave   bus,
  output logic [CNT_W-1:0] stall_cnt
);
  import id_stage_ctrl_pkg::*;

  id_state_e       state;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] pc_q;
  logic            use_rs1;
  logic            use_rs2;
  logic            full;
  logic            hz;
  logic            adv;
  logic            stall_inc;

  id_src_use u_src_use (
    .opcode  (inst_q[6:2]),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2)
  );

  // Hazard / advance decode from the held instruction and the EX-stage occupant
  always_comb begin
    full = (state == ST_FULL);
    hz   = full && bus.ex_valid && bus.ex_is_load && (bus.ex_rd != 5'd0) &&
           ((use_rs1 && (inst_q[19:15] == bus.ex_rd)) ||
            (use_rs2 && (inst_q[24:20] == bus.ex_rd)));
    adv       = (state == ST_EMPTY) || (full && !hz && bus.ex_ready);
    stall_inc = full && (hz || !bus.ex_ready);
  end

  assign bus.if_ready     = adv && !bus.flush && !rst;
  assign bus.id_valid     = full && !hz;
  assign bus.hazard_stall = full && hz;
  assign bus.id_inst      = inst_q;
  assign bus.id_pc        = pc_q;
  assign bus.id_rs1       = inst_q[19:15];
  assign bus.id_rs2       = inst_q[24:20];
  assign bus.id_rd        = inst_q[11:7];

  // Flush outranks everything; a HAZ cycle always returns to FULL with the same word
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      inst_q    <= NOP_INST;
      pc_q      <= '0;
      stall_cnt <= '0;
    end else begin
      if (!bus.flush && stall_inc) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (bus.flush) begin
        state  <= ST_EMPTY;
        inst_q <= NOP_INST;
      end else if (adv && bus.if_valid) begin
        state  <= ST_FULL;
        inst_q <= bus.if_inst;
        pc_q   <= bus.if_pc;
      end else if (adv) begin
        state <= ST_EMPTY;
      end else if (full && hz) begin
        state <= ST_HAZ;
      end else if (state == ST_HAZ) begin
        state <= ST_FULL;
      end
    end
  end

endmodule
